uart_tx_fifo_serializer: RTL and testbench



---
 rtl/uart_tx_fifo_serializer_if.sv | 19 +
 rtl/uart_tx_fifo_serializer.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo_serializer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_serializer_if.sv
// Byte push handshake between the UART TX register block and the serializer.
// The master drives start/data; the serializer answers with ready.
interface uart_tx_fifo_serializer_if;
  logic       start;
  logic [7:0] data;
  logic       ready;

  modport master (
    output start,
    output data,
    input  ready
  );

  modport slave (
    input  start,
    input  data,
    output ready
  );
endinterface

// File: rtl/uart_tx_fifo_serializer.sv
// 8N1 UART transmitter fed by a small circular transmit FIFO.
// Frames are chained back to back while the FIFO has data.
module uart_tx_fifo_serializer #(
  parameter int FMAX_MHz = 27,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  uart_tx_fifo_serializer_if.slave     bus,
  output logic                         uart_tx,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  localparam int CPB = (FMAX_MHz * 1_000_000) / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int CW  = (CPB < 2) ? 1 : $clog2(CPB);

  if (CPB < 2) begin : g_bad_baud
    $error("uart_tx_fifo_serializer: clocks per bit must be >= 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo_serializer: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   count_q;
  logic [7:0]      sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            tx_q, tx_d;
  logic            ovf_q;
  logic            full, empty, push, pop, tick;

  assign full      = (count_q == LW'(DEPTH));
  assign empty     = (count_q == '0);
  assign bus.ready = !full;
  assign push      = bus.start && !full;
  assign tick      = (cnt_q == CW'(CPB - 1));

  assign uart_tx  = tx_q;
  assign busy     = (state_q != IDLE) || !empty;
  assign level    = count_q;
  assign overflow = ovf_q;

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= bus.data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
      if (bus.start && full) ovf_q <= 1'b1;
    end
  end

  // Serializer state, shift register, baud counter and line register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // Frame sequencing: each bit is held for one full baud period.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = mem[rptr_q];
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          cnt_d   = '0;
          tx_d    = sh_q[0];
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = mem[rptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
// Directed bench for uart_tx_fifo_serializer at 10 clocks per bit, DEPTH=4.
// Every line cycle of every frame is compared against the expected 8N1 bit.
module tb_uart_tx_fifo_serializer;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_tx;
  logic       busy;
  logic       overflow;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  logic [7:0] fb [10] = '{8'hC1, 8'h5A, 8'h3C, 8'h96, 8'hE7,
                          8'h28, 8'h7E, 8'h81, 8'hD4, 8'h6B};

  uart_tx_fifo_serializer_if u_if();

  uart_tx_fifo_serializer #(
    .FMAX_MHz (1),
    .BAUD     (100000),
    .DEPTH    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (u_if),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [7:0] b, input int first,
                              input int last, input int max_wait,
                              input string name);
    int   w;
    logic exp;
    if (first == 0) begin
      w = 0;
      while (uart_tx !== 1'b0 && w < max_wait) begin
        step();
        w++;
      end
      checks++;
      if (uart_tx !== 1'b0) begin
        errors++;
        $display("FAIL %s start: tx=%b after %0d cycles, required 0", name, uart_tx, w);
        return;
      end
    end
    for (int i = first; i <= last; i++) begin
      if (i < CPB) exp = 1'b0;
      else if (i >= 9 * CPB) exp = 1'b1;
      else exp = b[i / CPB - 1];
      checks++;
      if (uart_tx !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: tx=%b required %b", name, i, uart_tx, exp);
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    u_if.start = 1'b0;
    u_if.data = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    step();
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset tx: got %b required 1", uart_tx); end
    checks++;
    if (level !== 3'd0) begin errors++; $display("FAIL reset level: got %0d required 0", level); end
    checks++;
    if (u_if.ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b required 1", u_if.ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b required 0", overflow); end
  endtask

  task automatic test_single();
    u_if.start = 1'b1;
    u_if.data = 8'h55;
    step();
    u_if.start = 1'b0;
    checks++;
    if (level !== 3'd1) begin errors++; $display("FAIL single level: got %0d required 1", level); end
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL single early tx: got %b required 1", uart_tx); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single busy: got %b required 1", busy); end
    expect_frame(8'h55, 0, 99, 1, "single");
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL single end: tx=%b busy=%b level=%0d required 1 0 0", uart_tx, busy, level);
    end
  endtask

  task automatic test_back_to_back();
    u_if.start = 1'b1;
    u_if.data = 8'hA3;
    step();
    checks++;
    if (level !== 3'd1) begin errors++; $display("FAIL b2b level0: got %0d required 1", level); end
    u_if.data = 8'h0F;
    step();
    u_if.start = 1'b0;
    checks++;
    if (level !== 3'd1) begin errors++; $display("FAIL b2b level1: got %0d required 1", level); end
    expect_frame(8'hA3, 0, 99, 0, "b2b_a3");
    expect_frame(8'h0F, 0, 99, 0, "b2b_0f");
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b end: tx=%b busy=%b required 1 0", uart_tx, busy);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      u_if.start = 1'b1;
      u_if.data = 8'h11 + 8'(i);
      step();
      if (i == 4) begin
        checks++;
        if (level !== 3'd4 || u_if.ready !== 1'b0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf full: level=%0d ready=%b ovf=%b required 4 0 0", level, u_if.ready, overflow);
        end
      end
      if (i == 5) begin
        checks++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
          errors++;
          $display("FAIL ovf drop: level=%0d ovf=%b required 4 1", level, overflow);
        end
      end
    end
    u_if.start = 1'b0;
    expect_frame(8'h11, 4, 99, 0, "ovf_11");
    expect_frame(8'h12, 0, 99, 0, "ovf_12");
    expect_frame(8'h13, 0, 99, 0, "ovf_13");
    expect_frame(8'h14, 0, 99, 0, "ovf_14");
    expect_frame(8'h15, 0, 99, 0, "ovf_15");
    for (int i = 0; i < 150; i++) begin
      checks++;
      if (uart_tx !== 1'b1) begin
        errors++;
        $display("FAIL ovf idle cycle %0d: tx=%b required 1", i, uart_tx);
      end
      step();
    end
    checks++;
    if (overflow !== 1'b1 || level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf end: ovf=%b level=%0d busy=%b required 1 0 0", overflow, level, busy);
    end
  endtask

  task automatic test_mid_frame_reset();
    u_if.start = 1'b1;
    u_if.data = 8'h00;
    step();
    u_if.start = 1'b0;
    step();
    repeat (35) step();
    checks++;
    if (uart_tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst mid: tx=%b busy=%b required 0 1", uart_tx, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst tx: got %b required 1", uart_tx); end
    checks++;
    if (level !== 3'd0 || busy !== 1'b0 || u_if.ready !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst state: level=%0d busy=%b ready=%b ovf=%b required 0 0 1 0",
               level, busy, u_if.ready, overflow);
    end
    for (int i = 0; i < 150; i++) begin
      checks++;
      if (uart_tx !== 1'b1) begin
        errors++;
        $display("FAIL rst idle cycle %0d: tx=%b required 1", i, uart_tx);
      end
      step();
    end
  endtask

  task automatic test_full_at_stop();
    for (int i = 0; i < 5; i++) begin
      u_if.start = 1'b1;
      u_if.data = fb[i];
      step();
    end
    u_if.start = 1'b0;
    checks++;
    if (level !== 3'd4 || u_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap full: level=%0d ready=%b required 4 0", level, u_if.ready);
    end
    expect_frame(fb[0], 3, 98, 0, "wrap_0");
    u_if.start = 1'b1;
    u_if.data = fb[5];
    step();
    checks++;
    if (level !== 3'd3 || u_if.ready !== 1'b1 || overflow !== 1'b1 || uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL wrap pop: level=%0d ready=%b ovf=%b tx=%b required 3 1 1 0",
               level, u_if.ready, overflow, uart_tx);
    end
    step();
    u_if.start = 1'b0;
    checks++;
    if (level !== 3'd4 || u_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap refill: level=%0d ready=%b required 4 0", level, u_if.ready);
    end
    expect_frame(fb[1], 1, 99, 0, "wrap_1");
    expect_frame(fb[2], 0, 99, 0, "wrap_2");
    expect_frame(fb[3], 0, 99, 0, "wrap_3");
    expect_frame(fb[4], 0, 99, 0, "wrap_4");
    expect_frame(fb[5], 0, 99, 0, "wrap_5");
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap gap: tx=%b busy=%b required 1 0", uart_tx, busy);
    end
    for (int i = 6; i < 10; i++) begin
      u_if.start = 1'b1;
      u_if.data = fb[i];
      step();
    end
    u_if.start = 1'b0;
    expect_frame(fb[6], 2, 99, 0, "wrap_6");
    expect_frame(fb[7], 0, 99, 0, "wrap_7");
    expect_frame(fb[8], 0, 99, 0, "wrap_8");
    expect_frame(fb[9], 0, 99, 0, "wrap_9");
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL wrap end: tx=%b busy=%b level=%0d required 1 0 0", uart_tx, busy, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_mid_frame_reset();
    test_full_at_stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
